ram_port_arbiter: RTL and testbench

Shares one single-ported, async-read RAM between two requesters (port 0, port 1) using valid/ready request handshakes and registered read responses. Arbitration is round-robin, with at most one RAM access per cycle. An optional post-reset sweep clears the RAM to zero before any requests are served. The block sits between two client engines and the RAM instance and drives the RAM's addr/d/we pins directly.

---
 rtl/ram_port_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_port_arbiter
// Description : Round-robin arbiter sharing one single-ported, async-read RAM
//               between two valid/ready requesters. Read responses are
//               registered and returned exactly one cycle after the request
//               fires. At most one RAM access is issued per cycle.
//               Optional macro RAM_ARB_CLEAR_EN: after reset the RAM is swept
//               to zero (one word per cycle, DEPTH cycles) before any request
//               is served; busy is high during the sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  // port 0
  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic              p0_we,
  input  logic [AWIDTH-1:0] p0_addr,
  input  logic [DWIDTH-1:0] p0_wdata,
  output logic              p0_rvalid,
  output logic [DWIDTH-1:0] p0_rdata,
  input  logic              p0_rready,
  // port 1
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic              p1_we,
  input  logic [AWIDTH-1:0] p1_addr,
  input  logic [DWIDTH-1:0] p1_wdata,
  output logic              p1_rvalid,
  output logic [DWIDTH-1:0] p1_rdata,
  input  logic              p1_rready,
  // RAM pins
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_d,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_q,
  // status
  output logic              busy
);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_SERVE = 1'b1
  } state_t;

`ifdef RAM_ARB_CLEAR_EN
  localparam state_t c_RESET_STATE = S_CLEAR;
`else
  localparam state_t c_RESET_STATE = S_SERVE;
`endif

  // One extra bit so DEPTH == 2**AWIDTH is representable in the range test.
  localparam logic [AWIDTH:0]   c_DEPTH_EXT = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH-1:0] c_LAST_ADDR = AWIDTH'(DEPTH - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [AWIDTH-1:0]   r_clr_cnt;
  logic [AWIDTH-1:0]   w_clr_cnt_nxt;
  logic                r_last_grant;

  logic                r_p0_rvalid;
  logic [DWIDTH-1:0]   r_p0_rdata;
  logic                r_p1_rvalid;
  logic [DWIDTH-1:0]   r_p1_rdata;

  logic                w_serve;
  logic                w_elig0;
  logic                w_elig1;
  logic                w_grant0;
  logic                w_grant1;
  logic                w_sel_we;
  logic [AWIDTH-1:0]   w_sel_addr;
  logic [DWIDTH-1:0]   w_sel_wdata;
  logic                w_in_range;
  logic                w_rd_fire0;
  logic                w_rd_fire1;
  logic [DWIDTH-1:0]   w_rd_value;

  // State register and clear-sweep counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= c_RESET_STATE;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  // Next-state logic: sweep one word per cycle, then serve until reset.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    case (r_state)
      S_CLEAR: begin
        if (r_clr_cnt == c_LAST_ADDR) begin
          w_state_nxt   = S_SERVE;
          w_clr_cnt_nxt = '0;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + AWIDTH'(1);
        end
      end
      S_SERVE: begin
        w_state_nxt = S_SERVE;
      end
      default: begin
        w_state_nxt = c_RESET_STATE;
      end
    endcase
  end

  // Eligibility and round-robin grant; a port whose response slot is full
  // may still be granted if that response drains in the same cycle.
  always_comb begin
    w_serve  = (r_state == S_SERVE);
    w_elig0  = w_serve && p0_valid && (!r_p0_rvalid || p0_rready);
    w_elig1  = w_serve && p1_valid && (!r_p1_rvalid || p1_rready);
    // last_grant == 1 means port 0 wins a tie, and vice versa.
    w_grant0 = w_elig0 && (!w_elig1 ||  r_last_grant);
    w_grant1 = w_elig1 && (!w_elig0 || !r_last_grant);
  end

  assign p0_ready = w_grant0;
  assign p1_ready = w_grant1;

  // Select the fields of the winning request (grants are one-hot).
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    if (w_grant0) begin
      w_sel_we    = p0_we;
      w_sel_addr  = p0_addr;
      w_sel_wdata = p0_wdata;
    end else if (w_grant1) begin
      w_sel_we    = p1_we;
      w_sel_addr  = p1_addr;
      w_sel_wdata = p1_wdata;
    end
    w_in_range = ({1'b0, w_sel_addr} < c_DEPTH_EXT);
    w_rd_fire0 = w_grant0 && !p0_we;
    w_rd_fire1 = w_grant1 && !p1_we;
    // Out-of-range reads return zero rather than whatever the RAM drives.
    w_rd_value = w_in_range ? ram_q : '0;
  end

  // RAM pin drive: sweep writes during CLEAR, winning request during SERVE.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_d    = '0;
    if (r_state == S_CLEAR) begin
      ram_we   = 1'b1;
      ram_addr = r_clr_cnt;
      ram_d    = '0;
    end else if (w_grant0 || w_grant1) begin
      ram_addr = w_sel_addr;
      ram_d    = w_sel_wdata;
      ram_we   = w_sel_we && w_in_range;
    end
  end

  // Round-robin pointer follows the most recent fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (w_grant0) begin
      r_last_grant <= 1'b0;
    end else if (w_grant1) begin
      r_last_grant <= 1'b1;
    end
  end

  // Port 0 response slot: load on read fire, clear on drain, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p0_rvalid <= 1'b0;
      r_p0_rdata  <= '0;
    end else if (w_rd_fire0) begin
      r_p0_rvalid <= 1'b1;
      r_p0_rdata  <= w_rd_value;
    end else if (r_p0_rvalid && p0_rready) begin
      r_p0_rvalid <= 1'b0;
    end
  end

  // Port 1 response slot: load on read fire, clear on drain, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p1_rvalid <= 1'b0;
      r_p1_rdata  <= '0;
    end else if (w_rd_fire1) begin
      r_p1_rvalid <= 1'b1;
      r_p1_rdata  <= w_rd_value;
    end else if (r_p1_rvalid && p1_rready) begin
      r_p1_rvalid <= 1'b0;
    end
  end

  assign p0_rvalid = r_p0_rvalid;
  assign p0_rdata  = r_p0_rdata;
  assign p1_rvalid = r_p1_rvalid;
  assign p1_rdata  = r_p1_rdata;

`ifdef RAM_ARB_CLEAR_EN
  assign busy = (r_state == S_CLEAR);
`else
  assign busy = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_port_arbiter
// Description : Directed self-checking bench for ram_port_arbiter with a
//               behavioural async-read RAM. DEPTH is 200 so that addresses
//               200..255 exercise the out-of-range path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

  localparam int c_DW    = 32;
  localparam int c_AW    = 8;
  localparam int c_DEPTH = 200;
`ifdef RAM_ARB_CLEAR_EN
  localparam bit c_CLR = 1'b1;
`else
  localparam bit c_CLR = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              p0_valid, p0_ready, p0_we, p0_rvalid, p0_rready;
  logic [c_AW-1:0]   p0_addr;
  logic [c_DW-1:0]   p0_wdata, p0_rdata;
  logic              p1_valid, p1_ready, p1_we, p1_rvalid, p1_rready;
  logic [c_AW-1:0]   p1_addr;
  logic [c_DW-1:0]   p1_wdata, p1_rdata;
  logic [c_AW-1:0]   ram_addr;
  logic [c_DW-1:0]   ram_d, ram_q;
  logic              ram_we;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [c_DW-1:0] mem [0:255];

  ram_port_arbiter #(.DWIDTH(c_DW), .AWIDTH(c_AW), .DEPTH(c_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_rready(p0_rready),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_rready(p1_rready),
    .ram_addr(ram_addr), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: async read, write at the clock edge.
  assign ram_q = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_d;

  function automatic logic [c_DW-1:0] init_pat(input int a);
    return 32'hA500_0000 | 32'(a);
  endfunction

  // Expected content of an untouched in-range word after a reset.
  function automatic logic [c_DW-1:0] fresh(input int a);
    return c_CLR ? 32'h0 : init_pat(a);
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_pat(i);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    p0_valid = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0; p0_rready = 1;
    p1_valid = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0; p1_rready = 1;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    if (c_CLR) repeat (c_DEPTH) tick();
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1;
    tick();
    tick();
    n_checks++; if (p0_rvalid !== 1'b0) begin n_errors++; $display("FAIL rst_p0_rvalid got %b exp 0", p0_rvalid); end
    n_checks++; if (p1_rvalid !== 1'b0) begin n_errors++; $display("FAIL rst_p1_rvalid got %b exp 0", p1_rvalid); end
    n_checks++; if (p0_rdata !== 32'h0) begin n_errors++; $display("FAIL rst_p0_rdata got %h exp 0", p0_rdata); end
    n_checks++; if (p1_rdata !== 32'h0) begin n_errors++; $display("FAIL rst_p1_rdata got %h exp 0", p1_rdata); end
    n_checks++; if (busy !== c_CLR) begin n_errors++; $display("FAIL rst_busy got %b exp %b", busy, c_CLR); end
    rst = 0;
  endtask

`ifdef RAM_ARB_CLEAR_EN
  task automatic test_clear;
    p0_valid = 1; p1_valid = 1;
    for (int i = 0; i < c_DEPTH; i++) begin
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL clr_busy[%0d] got %b exp 1", i, busy); end
      n_checks++; if (ram_we !== 1'b1) begin n_errors++; $display("FAIL clr_we[%0d] got %b exp 1", i, ram_we); end
      n_checks++; if (ram_addr !== 8'(i)) begin n_errors++; $display("FAIL clr_addr got %0d exp %0d", ram_addr, i); end
      n_checks++; if (ram_d !== 32'h0) begin n_errors++; $display("FAIL clr_d[%0d] got %h exp 0", i, ram_d); end
      n_checks++; if ((p0_ready | p1_ready) !== 1'b0) begin n_errors++; $display("FAIL clr_ready[%0d] got %b%b exp 00", i, p0_ready, p1_ready); end
      tick();
    end
    p0_valid = 0; p1_valid = 0;
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL clr_done_busy got %b exp 0", busy); end
    n_checks++; if (mem[199] !== 32'h0) begin n_errors++; $display("FAIL clr_mem199 got %h exp 0", mem[199]); end
  endtask
`endif

  task automatic test_read_first;
    p0_valid = 1; p0_we = 0; p0_addr = 8'd5; p0_rready = 1;
    #1;
    n_checks++; if (p0_ready !== 1'b1) begin n_errors++; $display("FAIL rd5_ready got %b exp 1", p0_ready); end
    n_checks++; if (ram_addr !== 8'd5 || ram_we !== 1'b0) begin n_errors++; $display("FAIL rd5_ram got addr %0d we %b exp 5/0", ram_addr, ram_we); end
    tick();
    p0_valid = 0;
    n_checks++; if (p0_rvalid !== 1'b1) begin n_errors++; $display("FAIL rd5_rvalid got %b exp 1", p0_rvalid); end
    n_checks++; if (p0_rdata !== fresh(5)) begin n_errors++; $display("FAIL rd5_rdata got %h exp %h", p0_rdata, fresh(5)); end
    tick();
    n_checks++; if (p0_rvalid !== 1'b0) begin n_errors++; $display("FAIL rd5_drain got %b exp 0", p0_rvalid); end
  endtask

  task automatic test_write_read;
    p0_valid = 1; p0_we = 1; p0_addr = 8'd3; p0_wdata = 32'h0000_1234;
    #1;
    n_checks++; if (p0_ready !== 1'b1 || ram_we !== 1'b1) begin n_errors++; $display("FAIL wr3 got ready %b we %b exp 1/1", p0_ready, ram_we); end
    n_checks++; if (ram_addr !== 8'd3 || ram_d !== 32'h1234) begin n_errors++; $display("FAIL wr3_ram got %0d/%h exp 3/1234", ram_addr, ram_d); end
    tick();
    p0_we = 0;
    #1;
    n_checks++; if (p0_rvalid !== 1'b0) begin n_errors++; $display("FAIL wr3_noresp got %b exp 0", p0_rvalid); end
    tick();
    p0_valid = 0;
    n_checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== 32'h1234) begin n_errors++; $display("FAIL rd3 got %b/%h exp 1/00001234", p0_rvalid, p0_rdata); end
    tick();
  endtask

  task automatic test_round_robin;
    do_reset();
    p0_valid = 1; p0_addr = 8'd10;
    p1_valid = 1; p1_addr = 8'd11;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_checks++; if (p0_ready !== (i % 2 == 0) || p1_ready !== (i % 2 == 1)) begin n_errors++; $display("FAIL rr_grant[%0d] got %b%b exp %b%b", i, p0_ready, p1_ready, (i % 2 == 0), (i % 2 == 1)); end
      n_checks++; if (p0_rvalid !== (i % 2 == 1)) begin n_errors++; $display("FAIL rr_p0_rvalid[%0d] got %b exp %b", i, p0_rvalid, (i % 2 == 1)); end
      n_checks++; if (p1_rvalid !== (i >= 2 && i % 2 == 0)) begin n_errors++; $display("FAIL rr_p1_rvalid[%0d] got %b exp %b", i, p1_rvalid, (i >= 2 && i % 2 == 0)); end
      if (i % 2 == 1) begin
        n_checks++; if (p0_rdata !== fresh(10)) begin n_errors++; $display("FAIL rr_p0_rdata[%0d] got %h exp %h", i, p0_rdata, fresh(10)); end
      end
      tick();
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_backpressure;
    do_reset();
    p0_valid = 1; p0_addr = 8'd12; p0_rready = 0;
    #1;
    n_checks++; if (p0_ready !== 1'b1) begin n_errors++; $display("FAIL bp_c0_ready got %b exp 1", p0_ready); end
    tick();
    p0_addr = 8'd14; p1_valid = 1; p1_addr = 8'd13;
    #1;
    n_checks++; if (p0_ready !== 1'b0 || p1_ready !== 1'b1) begin n_errors++; $display("FAIL bp_c1_grant got %b%b exp 01", p0_ready, p1_ready); end
    n_checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== fresh(12)) begin n_errors++; $display("FAIL bp_c1_p0resp got %b/%h exp 1/%h", p0_rvalid, p0_rdata, fresh(12)); end
    tick();
    #1;
    n_checks++; if (p0_ready !== 1'b0 || p1_ready !== 1'b1) begin n_errors++; $display("FAIL bp_c2_grant got %b%b exp 01", p0_ready, p1_ready); end
    n_checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== fresh(12)) begin n_errors++; $display("FAIL bp_c2_hold got %b/%h exp 1/%h", p0_rvalid, p0_rdata, fresh(12)); end
    n_checks++; if (p1_rvalid !== 1'b1 || p1_rdata !== fresh(13)) begin n_errors++; $display("FAIL bp_c2_p1resp got %b/%h exp 1/%h", p1_rvalid, p1_rdata, fresh(13)); end
    tick();
    p0_rready = 1;
    #1;
    n_checks++; if (p0_ready !== 1'b1 || p1_ready !== 1'b0) begin n_errors++; $display("FAIL bp_c3_regrant got %b%b exp 10", p0_ready, p1_ready); end
    tick();
    p0_valid = 0; p1_valid = 0;
    #1;
    n_checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== fresh(14)) begin n_errors++; $display("FAIL bp_c4_b2b got %b/%h exp 1/%h", p0_rvalid, p0_rdata, fresh(14)); end
    n_checks++; if (p1_rvalid !== 1'b0) begin n_errors++; $display("FAIL bp_c4_p1drain got %b exp 0", p1_rvalid); end
    tick();
    n_checks++; if (p0_rvalid !== 1'b0) begin n_errors++; $display("FAIL bp_c5_drain got %b exp 0", p0_rvalid); end
  endtask

  task automatic test_collision;
    do_reset();
    p0_valid = 1; p0_we = 1; p0_addr = 8'd7; p0_wdata = 32'h0000_CAFE;
    p1_valid = 1; p1_we = 0; p1_addr = 8'd7;
    #1;
    n_checks++; if (p0_ready !== 1'b1 || p1_ready !== 1'b0 || ram_we !== 1'b1) begin n_errors++; $display("FAIL col_c0 got rdy %b%b we %b exp 10/1", p0_ready, p1_ready, ram_we); end
    tick();
    p0_valid = 0; p0_we = 0;
    #1;
    n_checks++; if (p1_ready !== 1'b1 || ram_addr !== 8'd7) begin n_errors++; $display("FAIL col_c1 got rdy %b addr %0d exp 1/7", p1_ready, ram_addr); end
    tick();
    p1_valid = 0;
    n_checks++; if (p1_rvalid !== 1'b1 || p1_rdata !== 32'h0000_CAFE) begin n_errors++; $display("FAIL col_c2 got %b/%h exp 1/0000cafe", p1_rvalid, p1_rdata); end
    tick();
  endtask

  task automatic test_out_of_range;
    p1_valid = 1; p1_we = 1; p1_addr = 8'd250; p1_wdata = 32'h0000_DEAD;
    #1;
    n_checks++; if (p1_ready !== 1'b1 || ram_we !== 1'b0) begin n_errors++; $display("FAIL oor_wr got rdy %b we %b exp 1/0", p1_ready, ram_we); end
    tick();
    p1_we = 0; p1_addr = 8'd199;
    #1;
    n_checks++; if (mem[250] !== init_pat(250)) begin n_errors++; $display("FAIL oor_mem got %h exp %h", mem[250], init_pat(250)); end
    n_checks++; if (p1_rvalid !== 1'b0 || p1_ready !== 1'b1) begin n_errors++; $display("FAIL oor_wr_noresp got rv %b rdy %b exp 0/1", p1_rvalid, p1_ready); end
    tick();
    p1_addr = 8'd250;
    #1;
    n_checks++; if (p1_rvalid !== 1'b1 || p1_rdata !== fresh(199)) begin n_errors++; $display("FAIL edge199 got %b/%h exp 1/%h", p1_rvalid, p1_rdata, fresh(199)); end
    n_checks++; if (p1_ready !== 1'b1) begin n_errors++; $display("FAIL oor_rd_ready got %b exp 1", p1_ready); end
    tick();
    p1_valid = 0;
    n_checks++; if (p1_rvalid !== 1'b1 || p1_rdata !== 32'h0) begin n_errors++; $display("FAIL oor_rd got %b/%h exp 1/0", p1_rvalid, p1_rdata); end
    tick();
  endtask

  task automatic test_reset_mid;
    p0_valid = 1; p0_we = 0; p0_addr = 8'd20;
    tick();
    p0_valid = 0; p0_rready = 0;
    n_checks++; if (p0_rvalid !== 1'b1) begin n_errors++; $display("FAIL mid_pending got %b exp 1", p0_rvalid); end
    rst = 1;
    tick();
    rst = 0;
    n_checks++; if (p0_rvalid !== 1'b0) begin n_errors++; $display("FAIL mid_drop got %b exp 0", p0_rvalid); end
    p0_rready = 1;
`ifdef RAM_ARB_CLEAR_EN
    repeat (100) tick();
    n_checks++; if (ram_addr !== 8'd100 || busy !== 1'b1) begin n_errors++; $display("FAIL mid_cnt100 got %0d busy %b exp 100/1", ram_addr, busy); end
    rst = 1;
    tick();
    rst = 0;
    p0_valid = 1; p1_valid = 1;
    for (int i = 0; i < c_DEPTH; i++) begin
      n_checks++; if (busy !== 1'b1 || ram_addr !== 8'(i)) begin n_errors++; $display("FAIL mid_sweep[%0d] got busy %b addr %0d", i, busy, ram_addr); end
      n_checks++; if ((p0_ready | p1_ready) !== 1'b0) begin n_errors++; $display("FAIL mid_ready[%0d] got %b%b exp 00", i, p0_ready, p1_ready); end
      tick();
    end
    p0_valid = 0; p1_valid = 0;
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL mid_done got %b exp 0", busy); end
`endif
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
`ifdef RAM_ARB_CLEAR_EN
    test_clear();
`endif
    test_read_first();
    test_write_read();
    test_round_robin();
    test_backpressure();
    test_collision();
    test_out_of_range();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
